// File: rtl/sound_sequencer.sv
// sound_sequencer: turns single-cycle game events into timed tone requests
// for the pong sound card. Priority is goal > pong > ping. A goal plays
// GOAL_BEEPS beeps. Every tone or beep is followed by a silent gap.
// Optional feature: define SOUND_QUEUE_EN to add a 1-entry pending register.
// With it, a lower-priority event that arrives during a tone is played after
// the current tone finishes, instead of being dropped.
module sound_sequencer #(
    parameter int CNT_W      = 24,
    parameter int PING_LEN   = 1200000,
    parameter int PONG_LEN   = 1200000,
    parameter int GOAL_LEN   = 2400000,
    parameter int GAP_LEN    = 600000,
    parameter int GOAL_BEEPS = 3
) (
    input  logic       snd_clk,
    input  logic       rstn,
    input  logic       ev_ping,
    input  logic       ev_pong,
    input  logic       ev_goal,
    output logic [1:0] sound,
    output logic       mute,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam logic [CNT_W-1:0] PING_LD = CNT_W'(PING_LEN - 1);
    localparam logic [CNT_W-1:0] PONG_LD = CNT_W'(PONG_LEN - 1);
    localparam logic [CNT_W-1:0] GOAL_LD = CNT_W'(GOAL_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_LEN - 1);
    localparam logic [2:0]       BEEPS   = 3'(GOAL_BEEPS);
    localparam logic [1:0]       C_NONE  = 2'd0;
    localparam logic [1:0]       C_GOAL  = 2'd3;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       beep, beep_n;
    logic [1:0]       sound_n;
    logic             mute_n;
    logic             busy_n;
    logic [1:0]       ev_code;
    logic [1:0]       pend_n;
`ifdef SOUND_QUEUE_EN
    logic [1:0]       pend;
`endif

    // The tone code doubles as the priority value (ping=1 < pong=2 < goal=3)
    function automatic logic [CNT_W-1:0] tone_ld(input logic [1:0] code);
        case (code)
            2'd1:    tone_ld = PING_LD;
            2'd2:    tone_ld = PONG_LD;
            default: tone_ld = GOAL_LD;
        endcase
    endfunction

    // Simultaneous events collapse to the highest priority; the rest are lost
    always_comb begin
        ev_code = C_NONE;
        if (ev_goal)      ev_code = 2'd3;
        else if (ev_pong) ev_code = 2'd2;
        else if (ev_ping) ev_code = 2'd1;
    end

    // Next-state and registered-output computation
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        beep_n  = beep;
        sound_n = sound;
        mute_n  = mute;
`ifdef SOUND_QUEUE_EN
        pend_n  = pend;
`else
        pend_n  = C_NONE;
`endif
        if (ev_code != C_NONE && (state == IDLE || ev_code >= sound)) begin
            // New or equal/higher-priority event (re)starts a tone; pending is untouched
            state_n = PLAY;
            sound_n = ev_code;
            mute_n  = 1'b0;
            cnt_n   = tone_ld(ev_code);
            beep_n  = (ev_code == C_GOAL) ? 3'd1 : 3'd0;
        end else begin
`ifdef SOUND_QUEUE_EN
            // Lower-priority event: keep the best of stored and new
            if (ev_code != C_NONE && ev_code > pend) pend_n = ev_code;
`endif
            case (state)
                PLAY: begin
                    if (cnt == '0) begin
                        state_n = GAP;
                        mute_n  = 1'b1;
                        cnt_n   = GAP_LD;
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - CNT_W'(1);
                    end else if (sound == C_GOAL && beep < BEEPS) begin
                        state_n = PLAY;
                        mute_n  = 1'b0;
                        cnt_n   = GOAL_LD;
                        beep_n  = beep + 3'd1;
                    end else if (pend_n != C_NONE) begin
                        // Pending event goes straight to PLAY, skipping IDLE
                        state_n = PLAY;
                        sound_n = pend_n;
                        mute_n  = 1'b0;
                        cnt_n   = tone_ld(pend_n);
                        beep_n  = (pend_n == C_GOAL) ? 3'd1 : 3'd0;
                        pend_n  = C_NONE;
                    end else begin
                        state_n = IDLE;
                        sound_n = C_NONE;
                        mute_n  = 1'b1;
                        cnt_n   = '0;
                        beep_n  = 3'd0;
                    end
                end
                default: ;
            endcase
        end
        busy_n = (state_n != IDLE);
    end

    // State and output registers
    always_ff @(posedge snd_clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            beep  <= 3'd0;
            sound <= C_NONE;
            mute  <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            beep  <= beep_n;
            sound <= sound_n;
            mute  <= mute_n;
            busy  <= busy_n;
        end
    end

`ifdef SOUND_QUEUE_EN
    // Single-entry pending event
    always_ff @(posedge snd_clk or negedge rstn) begin
        if (!rstn) pend <= C_NONE;
        else       pend <= pend_n;
    end
`endif

endmodule
